// File: rtl/raiz_pkg.sv
//------------------------------------------------------------------------------
// Module  : raiz_pkg
// Brief   : Shared types and constants for the square-root sequencing controller.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package raiz_pkg;

  // Iteration count used when the instantiating level does not override it.
  localparam int unsigned C_N_ITER_DEF = 8;

  // Width of the iteration counter; holds any legal N_ITER (1..31).
  localparam int unsigned C_CNT_W = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_TEST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage : raiz_pkg

`default_nettype wire

// File: rtl/cnt_iter_raiz.sv
//------------------------------------------------------------------------------
// Module  : cnt_iter_raiz
// Brief   : Loadable saturating down counter with a registered last-iteration flag.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cnt_iter_raiz
  import raiz_pkg::*;
#(
  parameter int unsigned LOAD_VAL = C_N_ITER_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic LD,
  input  logic SH,
  output logic Z
);

  localparam logic [C_CNT_W-1:0] C_ONE  = C_CNT_W'(1);
  localparam logic [C_CNT_W-1:0] C_LOAD = C_CNT_W'(LOAD_VAL);

  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic               z_q, z_d;

  // Z is captured on the shift that consumes the last count, so it is seen
  // by the following TEST cycle and never earlier.
  always_comb begin
    cnt_d = cnt_q;
    z_d   = z_q;
    if (LD) begin
      cnt_d = C_LOAD;
      z_d   = 1'b0;
    end else if (SH) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - C_ONE;
      end
      if (cnt_q == C_ONE) begin
        z_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      z_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      z_q   <= z_d;
    end
  end

  assign Z = z_q;

endmodule : cnt_iter_raiz

`default_nettype wire

// File: rtl/ctrl_raiz.sv
//------------------------------------------------------------------------------
// Module  : ctrl_raiz
// Brief   : Sequencer for the restoring square-root datapath (load, N shift/test
//           iterations, done pulse). Define CTRL_RAIZ_ABORT_EN to add ABORT.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ctrl_raiz
  import raiz_pkg::*;
#(
  parameter int unsigned N_ITER = C_N_ITER_DEF  // legal range 1..31
) (
  input  logic CLK,
  input  logic RST,
  input  logic INIT,
  input  logic K,
`ifdef CTRL_RAIZ_ABORT_EN
  input  logic ABORT,
`endif
  output logic LD,
  output logic SH,
  output logic SUB,
  output logic BUSY,
  output logic DONE
);

  state_t state_q, state_d;
  logic   w_z;
  logic   w_abort;

`ifdef CTRL_RAIZ_ABORT_EN
  // Abort only acts while the datapath is mid-operation; IDLE and DONE ignore it.
  assign w_abort = ABORT && ((state_q == S_LOAD) || (state_q == S_SHIFT) ||
                             (state_q == S_TEST));
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (INIT) state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: state_d = S_TEST;
      S_TEST:  state_d = w_z ? S_DONE : S_SHIFT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (w_abort) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    LD   = 1'b0;
    SH   = 1'b0;
    SUB  = 1'b0;
    BUSY = 1'b0;
    DONE = 1'b0;
    LD   = (state_q == S_LOAD);
    SH   = (state_q == S_SHIFT);
    BUSY = (state_q != S_IDLE);
    DONE = (state_q == S_DONE);
    // Commit is suppressed on an aborting cycle so the datapath is left untouched.
    SUB  = (state_q == S_TEST) && K && !w_abort;
  end

  cnt_iter_raiz #(
    .LOAD_VAL (N_ITER)
  ) u_cnt (
    .CLK (CLK),
    .RST (RST),
    .LD  (LD),
    .SH  (SH),
    .Z   (w_z)
  );

endmodule : ctrl_raiz

`default_nettype wire

// File: tb/tb_ctrl_raiz.sv
//------------------------------------------------------------------------------
// Module  : tb_ctrl_raiz
// Brief   : Table-driven self-checking bench for ctrl_raiz (N_ITER = 8, 1, 31).
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ctrl_raiz;

  typedef struct packed {
    logic       init;
    logic       k;
    logic       rst;
    logic       abort;
    logic [4:0] exp;   // {LD, SH, SUB, BUSY, DONE}
  } vec_t;

  localparam int TBL_LEN = 21;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init = 1'b0;
  logic k = 1'b0;
  logic abort = 1'b0;
  logic init_b = 1'b0;

  logic ld, sh, sub, busy, done;
  logic ld1, sh1, sub1, busy1, done1;
  logic ld31, sh31, sub31, busy31, done31;

  vec_t tbl [TBL_LEN];

  int checks = 0;
  int failures = 0;

  int ld1_first, sh1_first, sub1_first, done1_first, done1_cnt;
  int ld31_first, done31_first, done31_cnt, sub31_cnt;
  logic [4:0] main_or;

  always #5 clk = ~clk;

  ctrl_raiz #(.N_ITER(8)) dut (
    .CLK  (clk),
    .RST  (rst),
    .INIT (init),
    .K    (k),
`ifdef CTRL_RAIZ_ABORT_EN
    .ABORT(abort),
`endif
    .LD   (ld),
    .SH   (sh),
    .SUB  (sub),
    .BUSY (busy),
    .DONE (done)
  );

  ctrl_raiz #(.N_ITER(1)) dut1 (
    .CLK  (clk),
    .RST  (rst),
    .INIT (init_b),
    .K    (k),
`ifdef CTRL_RAIZ_ABORT_EN
    .ABORT(1'b0),
`endif
    .LD   (ld1),
    .SH   (sh1),
    .SUB  (sub1),
    .BUSY (busy1),
    .DONE (done1)
  );

  ctrl_raiz #(.N_ITER(31)) dut31 (
    .CLK  (clk),
    .RST  (rst),
    .INIT (init_b),
    .K    (k),
`ifdef CTRL_RAIZ_ABORT_EN
    .ABORT(1'b0),
`endif
    .LD   (ld31),
    .SH   (sh31),
    .SUB  (sub31),
    .BUSY (busy31),
    .DONE (done31)
  );

  task automatic chk(input string name, input int c, input logic [4:0] got,
                     input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got{LD,SH,SUB,BUSY,DONE}=%b required=%b",
               name, c, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  // Expected outputs of an N_ITER=8 run whose INIT was sampled at edge 0.
  function automatic logic [4:0] basic_exp(input int c, input logic kv);
    logic l, s, t, b, d;
    l = (c == 1);
    s = (c >= 2) && (c <= 16) && (c % 2 == 0);
    t = (c >= 3) && (c <= 17) && (c % 2 == 1);
    b = (c >= 1) && (c <= 18);
    d = (c == 18);
    return {l, s, t & kv, b, d};
  endfunction

  task automatic fill_basic(input logic kv);
    for (int c = 0; c < TBL_LEN; c++) begin
      tbl[c]      = '0;
      tbl[c].init = (c == 0);
      tbl[c].k    = kv;
      tbl[c].exp  = basic_exp(c, kv);
    end
  endtask

  // Entered just after a rising edge with the DUT in IDLE; row c drives cycle c.
  task automatic apply(input string name);
    for (int c = 0; c < TBL_LEN; c++) begin
      init  = tbl[c].init;
      k     = tbl[c].k;
      rst   = tbl[c].rst;
      abort = tbl[c].abort;
      @(negedge clk);
      chk(name, c, {ld, sh, sub, busy, done}, tbl[c].exp);
      @(posedge clk);
      #1;
    end
    init  = 1'b0;
    k     = 1'b0;
    rst   = 1'b0;
    abort = 1'b0;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    init = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset with INIT high: reset must win and every output stays low.
    rst  = 1'b1;
    init = 1'b1;
    init_b = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_main", 0, {ld, sh, sub, busy, done}, 5'b00000);
    chk("reset_n1", 0, {ld1, sh1, sub1, busy1, done1}, 5'b00000);
    chk("reset_n31", 0, {ld31, sh31, sub31, busy31, done31}, 5'b00000);
    init   = 1'b0;
    init_b = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    fill_basic(1'b0);
    apply("k0_run");

    fill_basic(1'b1);
    apply("k1_run");

    fill_basic(1'b0);
    tbl[5].init  = 1'b1;
    tbl[18].init = 1'b1;
    apply("init_ignored");

    fill_basic(1'b0);
    for (int c = 0; c < TBL_LEN; c++) tbl[c].init = 1'b1;
    tbl[20].exp = 5'b10010;
    apply("init_held");
    do_reset();

    fill_basic(1'b0);
    tbl[7].rst = 1'b1;
    for (int c = 8; c < TBL_LEN; c++) tbl[c].exp = 5'b00000;
    apply("rst_mid");

    fill_basic(1'b0);
    apply("after_rst");

`ifdef CTRL_RAIZ_ABORT_EN
    fill_basic(1'b1);
    tbl[9].abort = 1'b1;
    tbl[9].exp   = 5'b00010;
    for (int c = 10; c < TBL_LEN; c++) tbl[c].exp = 5'b00000;
    apply("abort_test");

    fill_basic(1'b1);
    tbl[0].abort = 1'b1;
    apply("after_abort");
`endif

    // N_ITER = 1 and 31 run side by side; K=1 also exercises K while dut idles.
    ld1_first = -1; sh1_first = -1; sub1_first = -1; done1_first = -1; done1_cnt = 0;
    ld31_first = -1; done31_first = -1; done31_cnt = 0; sub31_cnt = 0;
    main_or = 5'b00000;
    k      = 1'b1;
    init_b = 1'b1;
    @(posedge clk);
    #1;
    init_b = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (ld1 && ld1_first < 0) ld1_first = c;
      if (sh1 && sh1_first < 0) sh1_first = c;
      if (sub1 && sub1_first < 0) sub1_first = c;
      if (done1) begin
        done1_cnt++;
        if (done1_first < 0) done1_first = c;
      end
      if (ld31 && ld31_first < 0) ld31_first = c;
      if (sub31) sub31_cnt++;
      if (done31) begin
        done31_cnt++;
        if (done31_first < 0) done31_first = c;
      end
      main_or = main_or | {ld, sh, sub, busy, done};
      @(posedge clk);
      #1;
    end
    k = 1'b0;
    chk_int("n1_ld_cycle", ld1_first, 1);
    chk_int("n1_sh_cycle", sh1_first, 2);
    chk_int("n1_test_cycle", sub1_first, 3);
    chk_int("n1_done_cycle", done1_first, 4);
    chk_int("n1_done_count", done1_cnt, 1);
    chk_int("n31_ld_cycle", ld31_first, 1);
    chk_int("n31_sub_count", sub31_cnt, 31);
    chk_int("n31_done_cycle", done31_first, 64);
    chk_int("n31_done_count", done31_cnt, 1);
    chk("idle_k_no_effect", 70, main_or, 5'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ctrl_raiz

`default_nettype wire

// File: doc/ctrl_raiz.md
# ctrl_raiz

Sequencing controller for the calculator's restoring square-root unit. Accepts a start request, drives the square-root datapath through load, N shift/test iterations and completion, and signals the result as valid. Owns the iteration counter internally, so the datapath sees only the load, shift and subtract strobes plus a completion pulse. Sits between the calculator's top-level operation decoder and the square-root datapath.

## Interface
- N_ITER, 8, number of shift/test iterations (one result bit each); legal 1..31
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  reset; synchronous, active-high
- INIT  in  1  start request, sampled only in IDLE
- K  in  1  datapath compare: remainder ≥ trial value, valid in TEST
- LD  out  1  datapath load radicand, clear remainder/root
- SH  out  1  datapath shift two radicand bits into remainder, root left by one
- SUB  out  1  datapath commit remainder −= trial, set root LSB
- BUSY  out  1  operation in progress (state ≠ IDLE)
- DONE  out  1  one-cycle pulse: root/remainder valid in datapath

## Operation
- States:
  - IDLE: INIT=1 → LOAD, else stay.
  - LOAD: LD=1; counter loads N_ITER, Z cleared → SHIFT.
  - SHIFT: SH=1; counter decrements → TEST.
  - TEST: SUB=K; Z=1 → DONE, else → SHIFT.
  - DONE: DONE=1 → IDLE unconditionally.
- LD, SH, BUSY, DONE are Moore decodes of the state register. SUB is Mealy: K gated by TEST.
- Counter: 5-bit down counter. Z sets on the SH cycle where count==1, clears on LD, holds otherwise. Count never decrements below 0.
- INIT outside IDLE is ignored, including in the DONE cycle. INIT held high restarts one cycle after DONE, via IDLE.
- Datapath results stay valid after DONE until the next LD. The controller does not touch them.
- K outside TEST has no effect.

## Timing
- Reset values: state=IDLE, count=0, Z=0; LD=SH=SUB=BUSY=DONE=0.
- RST=1 in any state → IDLE on the next edge, counter cleared, no DONE pulse. RST overrides INIT and ABORT.
- With INIT sampled at edge 0: LD high in cycle 1. SH in cycles 2,4,…,2N. TEST in cycles 3,5,…,2N+1. DONE in cycle 2N+2.
- For N_ITER=8, DONE is in cycle 18. BUSY is high in cycles 1–18.
- Earliest next LD after DONE: cycle 2N+4.
- Z is valid in the TEST cycle following the Nth SH, and not earlier.

## Configuration
- CTRL_RAIZ_ABORT_EN defined:
  - Adds input ABORT (1 bit).
  - ABORT=1 in LOAD, SHIFT or TEST → IDLE on the next edge, with no DONE pulse.
  - SUB is forced 0 in that cycle.
  - ABORT in IDLE or DONE is ignored.
- Undefined: no ABORT port; the FSM is exactly as above.

## Structure
- Package raiz_pkg:
  - State encoding constants, 3 bits: IDLE=0, LOAD=1, SHIFT=2, TEST=3, DONE=4.
  - Default N_ITER.
  - Counter width constant (5).
- Sub-module cnt_iter_raiz: the loadable down counter with registered Z. Ports: CLK, RST, LD, SH, Z; load value is a parameter.
- ctrl_raiz holds the FSM, the output decode and the abort gating.

## Test plan
- N_ITER=8, INIT pulse at edge 0, K=0 throughout → LD cycle 1. SH in cycles 2,4,…,16. SUB never. DONE single pulse in cycle 18. BUSY in cycles 1–18.
- Same run with K=1 throughout → 8 SUB pulses in cycles 3,5,…,17. Counts of LD/SH/DONE are unchanged.
- INIT re-pulsed in cycles 5 and 18 → ignored; single DONE in cycle 18. INIT held high from cycle 0 → second LD in cycle 20.
- RST asserted in cycle 7 → IDLE in cycle 8, outputs 0, no DONE. A fresh INIT gives a full 18-cycle run with DONE in relative cycle 18.
- N_ITER=1 → LD 1, SH 2, TEST 3, DONE 4. N_ITER=31 → DONE in cycle 64.
- With CTRL_RAIZ_ABORT_EN, ABORT in cycle 9 while K=1 → SUB=0 that cycle, IDLE next, no DONE. A following INIT runs normally.
